// File: rtl/motion_pkg.sv
// Shared types and constants for the sprite motion engine.
//   motion_mode_t : FSM state, also exported on the mode output
//   HIT_*         : bit positions inside the 4-bit hit-edge code {L,T,R,B}
//   fix_t         : signed fixed-point word used for position and velocity
//   sat()         : saturate a fixed-point value to [lo, hi]
package motion_pkg;

  localparam int unsigned FIX_W = 32;
  localparam int unsigned PIX_W = 11;

  localparam int unsigned HIT_L = 3;
  localparam int unsigned HIT_T = 2;
  localparam int unsigned HIT_R = 1;
  localparam int unsigned HIT_B = 0;

  typedef enum logic [1:0] {
    AIR    = 2'd0,
    LANDED = 2'd1,
    FROZEN = 2'd2
  } motion_mode_t;

  typedef logic signed [FIX_W-1:0] fix_t;

  // Saturate v into [lo, hi].
  function automatic fix_t sat(input fix_t v, input fix_t lo, input fix_t hi);
    fix_t r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion_engine_if.sv
// Control/status bundle between game logic and the sprite motion engine.
//   start_of_frame : one-cycle frame strobe
//   jump_*_n       : active-low jump buttons (debounced upstream)
//   hit_pulse/edge : collision strobe and {L,T,R,B} edge code
//   freeze         : hold all motion
//   top_left_x/y   : sprite pixel position
//   landed, mode   : bottom-contact pulse and FSM state
// Modports: master = game logic side, slave = motion engine side.
interface sprite_motion_engine_if;
  import motion_pkg::*;

  logic                    start_of_frame;
  logic                    jump_left_n;
  logic                    jump_right_n;
  logic                    jump_up_n;
  logic                    hit_pulse;
  logic [3:0]              hit_edge;
  logic                    freeze;
  logic signed [PIX_W-1:0] top_left_x;
  logic signed [PIX_W-1:0] top_left_y;
  logic                    landed;
  motion_mode_t            mode;

  modport master (
    output start_of_frame, jump_left_n, jump_right_n, jump_up_n,
           hit_pulse, hit_edge, freeze,
    input  top_left_x, top_left_y, landed, mode
  );

  modport slave (
    input  start_of_frame, jump_left_n, jump_right_n, jump_up_n,
           hit_pulse, hit_edge, freeze,
    output top_left_x, top_left_y, landed, mode
  );

endinterface

// File: rtl/press_request_latch.sv
// Falling-edge detector on an active-low button with a sticky request flag.
//   clk, reset : clock, async active-high reset
//   btn_n      : active-low button level
//   clear      : drop the current request; a press in the same cycle survives
//   flush      : drop everything, including a press in the same cycle
//   req        : latched request
module press_request_latch (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic clear,
  input  logic flush,
  output logic req
);

  logic prev;
  logic fall;
  logic req_n;

  assign fall = prev & ~btn_n;

  // A press landing on the clearing cycle belongs to the next frame.
  always_comb begin
    req_n = 1'b0;
    if (!flush) req_n = (clear ? 1'b0 : req) | fall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b1;
      req  <= 1'b0;
    end else begin
      prev <= btn_n;
      req  <= req_n;
    end
  end

endmodule

// File: rtl/sprite_motion_engine.sv
// Per-frame fixed-point motion of a single sprite: gravity, wall/object
// collisions, edge-triggered jumps, speed clamping and freeze.
//   clk, reset : clock, async active-high reset
//   bus        : sprite_motion_engine_if.slave (frame strobe, buttons, hits,
//                freeze in; pixel position, landed pulse, mode out)
module sprite_motion_engine
  import motion_pkg::*;
#(
  parameter int FRAC_BITS     = 6,
  parameter int INITIAL_X     = 280,
  parameter int INITIAL_Y     = 185,
  parameter int INITIAL_VX    = 40,
  parameter int INITIAL_VY    = 20,
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 32,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  parameter int MARGIN        = 30,
  parameter int GRAVITY       = 10,
  parameter int JUMP_VX       = 100,
  parameter int JUMP_VY       = 150,
  parameter int MAX_V         = 600,
  parameter int BOUNCE_THRESH = 500,
  parameter int LAND_VY       = 150
) (
  input  logic                 clk,
  input  logic                 reset,
  sprite_motion_engine_if.slave bus
);

  localparam fix_t X_LO_PIX  = fix_t'(MARGIN);
  localparam fix_t Y_LO_PIX  = fix_t'(MARGIN);
  localparam fix_t X_HI_PIX  = fix_t'(FRAME_W - 1 - MARGIN - SPRITE_W);
  localparam fix_t Y_HI_PIX  = fix_t'(FRAME_H - 1 - MARGIN - SPRITE_H);
  localparam fix_t POS_X_MAX = fix_t'((FRAME_W - SPRITE_W) * (2 ** FRAC_BITS));
  localparam fix_t POS_Y_MAX = fix_t'((FRAME_H - SPRITE_H) * (2 ** FRAC_BITS));
  localparam fix_t POS_X_RST = fix_t'(INITIAL_X * (2 ** FRAC_BITS));
  localparam fix_t POS_Y_RST = fix_t'(INITIAL_Y * (2 ** FRAC_BITS));
  localparam fix_t V_MAX     = fix_t'(MAX_V);
  localparam fix_t V_MIN     = fix_t'(-MAX_V);

  motion_mode_t state, state_n;
  fix_t         pos_x, pos_y, vx, vy;
  fix_t         pos_x_n, pos_y_n, vx_n, vy_n;
  fix_t         vx_t, vy_t;
  fix_t         pix_x, pix_y;
  logic [3:0]   hits, hits_n;
  logic         landed_q, landed_n;
  logic         contact;
  logic         req_left, req_right, req_up;

  // Jump request latches: cleared by each frame, discarded while frozen.
  press_request_latch u_left (
    .clk(clk), .reset(reset), .btn_n(bus.jump_left_n),
    .clear(bus.start_of_frame), .flush(bus.freeze), .req(req_left)
  );
  press_request_latch u_right (
    .clk(clk), .reset(reset), .btn_n(bus.jump_right_n),
    .clear(bus.start_of_frame), .flush(bus.freeze), .req(req_right)
  );
  press_request_latch u_up (
    .clk(clk), .reset(reset), .btn_n(bus.jump_up_n),
    .clear(bus.start_of_frame), .flush(bus.freeze), .req(req_up)
  );

  // Floor-rounded pixel coordinates of the current position.
  assign pix_x = pos_x >>> FRAC_BITS;
  assign pix_y = pos_y >>> FRAC_BITS;

  // Next-state and frame physics.
  always_comb begin
    state_n  = state;
    pos_x_n  = pos_x;
    pos_y_n  = pos_y;
    vx_n     = vx;
    vy_n     = vy;
    landed_n = 1'b0;
    contact  = 1'b0;
    vx_t     = vx;
    vy_t     = vy;
    // A hit on the frame strobe is kept for the following frame.
    hits_n   = (bus.start_of_frame ? 4'b0000 : hits) |
               (bus.hit_pulse ? bus.hit_edge : 4'b0000);

    if (bus.freeze) begin
      state_n = FROZEN;
      hits_n  = 4'b0000;
    end else if (bus.start_of_frame) begin
      // Horizontal reflection only when moving into the wall.
      if ((pix_x <= X_LO_PIX || hits[HIT_L]) && vx < 0)
        vx_t = -vx;
      else if ((pix_x >= X_HI_PIX || hits[HIT_R]) && vx > 0)
        vx_t = -vx;

      // Ceiling reflects, floor stops horizontal motion and rebounds.
      if ((pix_y <= Y_LO_PIX || hits[HIT_T]) && vy <= 0) begin
        vy_t = -vy;
      end else if ((pix_y >= Y_HI_PIX || hits[HIT_B]) && vy >= 0) begin
        contact = 1'b1;
        vx_t    = '0;
        if (vy >= fix_t'(BOUNCE_THRESH)) vy_t = -(vy >>> 1);
        else                             vy_t = fix_t'(-LAND_VY);
      end else begin
        vy_t = vy + fix_t'(GRAVITY);
      end

      if (req_up) vy_t = vy_t - fix_t'(JUMP_VY);
      // Opposing side requests cancel; a blocked side cannot push.
      if (req_left && !req_right && !hits[HIT_L] && !contact)
        vx_t = fix_t'(-JUMP_VX);
      if (req_right && !req_left && !hits[HIT_R] && !contact)
        vx_t = fix_t'(JUMP_VX);

      vx_n     = sat(vx_t, V_MIN, V_MAX);
      vy_n     = sat(vy_t, V_MIN, V_MAX);
      pos_x_n  = sat(pos_x + vx_n, '0, POS_X_MAX);
      pos_y_n  = sat(pos_y + vy_n, '0, POS_Y_MAX);
      landed_n = contact;
      state_n  = contact ? LANDED : AIR;
    end else if (state == FROZEN) begin
      state_n = AIR;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= AIR;
      pos_x    <= POS_X_RST;
      pos_y    <= POS_Y_RST;
      vx       <= fix_t'(INITIAL_VX);
      vy       <= fix_t'(INITIAL_VY);
      hits     <= 4'b0000;
      landed_q <= 1'b0;
    end else begin
      state    <= state_n;
      pos_x    <= pos_x_n;
      pos_y    <= pos_y_n;
      vx       <= vx_n;
      vy       <= vy_n;
      hits     <= hits_n;
      landed_q <= landed_n;
    end
  end

  assign bus.top_left_x = PIX_W'(pix_x);
  assign bus.top_left_y = PIX_W'(pix_y);
  assign bus.landed     = landed_q;
  assign bus.mode       = state;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed bench for sprite_motion_engine: hand-computed scenarios followed
// by a longer run checked against a small behavioural model.
module tb_sprite_motion_engine;
  import motion_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state (fixed-point units).
  int m_x, m_y, m_vx, m_vy, m_mode, m_land;

  sprite_motion_engine_if bus();

  sprite_motion_engine dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.jump_left_n = 1'b1; bus.jump_right_n = 1'b1; bus.jump_up_n = 1'b1;
    bus.hit_pulse = 1'b0; bus.hit_edge = 4'b0000;
    bus.start_of_frame = 1'b0; bus.freeze = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Release buttons, press the requested ones, optional hit, then frame strobe.
  task automatic do_frame(input bit up, input bit left, input bit right, input logic [3:0] h);
    bus.jump_left_n = 1'b1; bus.jump_right_n = 1'b1; bus.jump_up_n = 1'b1;
    tick();
    bus.jump_left_n = ~left; bus.jump_right_n = ~right; bus.jump_up_n = ~up;
    tick();
    if (h != 4'b0000) begin
      bus.hit_pulse = 1'b1; bus.hit_edge = h;
      tick();
      bus.hit_pulse = 1'b0; bus.hit_edge = 4'b0000;
    end
    bus.start_of_frame = 1'b1;
    tick();
    bus.start_of_frame = 1'b0;
  endtask

  task automatic sof_only();
    bus.start_of_frame = 1'b1;
    tick();
    bus.start_of_frame = 1'b0;
  endtask

  task automatic model_reset();
    m_x = 280 * 64; m_y = 185 * 64; m_vx = 40; m_vy = 20; m_mode = 0; m_land = 0;
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_frame(input bit up, input bit left, input bit right, input logic [3:0] h);
    int px;
    int py;
    bit bot;
    px = m_x >>> 6;
    py = m_y >>> 6;
    bot = 1'b0;
    if ((px <= 30 || h[3]) && m_vx < 0) m_vx = -m_vx;
    else if ((px >= 577 || h[1]) && m_vx > 0) m_vx = -m_vx;
    if ((py <= 30 || h[2]) && m_vy <= 0) m_vy = -m_vy;
    else if ((py >= 417 || h[0]) && m_vy >= 0) begin
      bot = 1'b1;
      m_vx = 0;
      m_vy = (m_vy >= 500) ? -(m_vy >>> 1) : -150;
    end else m_vy = m_vy + 10;
    if (up) m_vy = m_vy - 150;
    if (left && !right && !h[3] && !bot) m_vx = -100;
    if (right && !left && !h[1] && !bot) m_vx = 100;
    m_vx = lim(m_vx, -600, 600);
    m_vy = lim(m_vy, -600, 600);
    m_x = lim(m_x + m_vx, 0, 608 * 64);
    m_y = lim(m_y + m_vy, 0, 448 * 64);
    m_land = bot ? 1 : 0;
    m_mode = bot ? 1 : 0;
  endtask

  task automatic model_check(input int f);
    chk($sformatf("run_px[%0d]", f), int'(bus.top_left_x), m_x >>> 6);
    chk($sformatf("run_py[%0d]", f), int'(bus.top_left_y), m_y >>> 6);
    chk($sformatf("run_vx[%0d]", f), int'(dut.vx), m_vx);
    chk($sformatf("run_vy[%0d]", f), int'(dut.vy), m_vy);
    chk($sformatf("run_mode[%0d]", f), int'(bus.mode), m_mode);
    chk($sformatf("run_landed[%0d]", f), int'(bus.landed), m_land);
  endtask

  initial begin
    // Reset state.
    do_reset();
    chk("rst_px", int'(bus.top_left_x), 280);
    chk("rst_py", int'(bus.top_left_y), 185);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_landed", int'(bus.landed), 0);
    chk("rst_vx", int'(dut.vx), 40);
    chk("rst_vy", int'(dut.vy), 20);

    // One quiet frame: gravity only.
    do_frame(0, 0, 0, 4'b0000);
    chk("f1_vy", int'(dut.vy), 30);
    chk("f1_pos_y", int'(dut.pos_y), 11870);
    chk("f1_py", int'(bus.top_left_y), 185);
    chk("f1_pos_x", int'(dut.pos_x), 17960);
    chk("f1_px", int'(bus.top_left_x), 280);
    chk("f1_mode", int'(bus.mode), 0);

    // Held jump-up button applies once.
    bus.jump_up_n = 1'b0;
    tick();
    sof_only();
    chk("hold_vy0", int'(dut.vy), -110);
    sof_only();
    chk("hold_vy1", int'(dut.vy), -100);
    sof_only();
    chk("hold_vy2", int'(dut.vy), -90);
    bus.jump_up_n = 1'b1;
    tick();

    // Left and right in the same frame cancel.
    do_reset();
    do_frame(0, 1, 1, 4'b0000);
    chk("cancel_vx", int'(dut.vx), 40);
    chk("cancel_px", int'(bus.top_left_x), 280);

    // Left jump, then a left hit reverses it and blocks a new left jump.
    do_reset();
    do_frame(0, 1, 0, 4'b0000);
    chk("jl_vx", int'(dut.vx), -100);
    chk("jl_px", int'(bus.top_left_x), 278);
    do_frame(0, 1, 0, 4'b1000);
    chk("hitl_vx", int'(dut.vx), 100);
    chk("hitl_px", int'(bus.top_left_x), 280);
    chk("hitl_py", int'(bus.top_left_y), 186);

    // Bottom hit: stop, rebound, landed pulse, LANDED mode.
    do_reset();
    do_frame(0, 0, 0, 4'b0001);
    chk("land_vx", int'(dut.vx), 0);
    chk("land_vy", int'(dut.vy), -150);
    chk("land_pulse", int'(bus.landed), 1);
    chk("land_mode", int'(bus.mode), 1);
    chk("land_py", int'(bus.top_left_y), 182);
    tick();
    chk("land_pulse_end", int'(bus.landed), 0);
    chk("land_mode_hold", int'(bus.mode), 1);
    do_frame(0, 0, 0, 4'b0000);
    chk("air_mode", int'(bus.mode), 0);
    chk("air_vy", int'(dut.vy), -140);
    chk("air_py", int'(bus.top_left_y), 180);

    // Freeze: frames, presses and hits are all ignored.
    bus.freeze = 1'b1;
    tick();
    chk("frz_mode", int'(bus.mode), 2);
    bus.jump_up_n = 1'b0;
    bus.hit_pulse = 1'b1; bus.hit_edge = 4'b0001;
    tick();
    bus.hit_pulse = 1'b0; bus.hit_edge = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      sof_only();
      tick();
    end
    chk("frz_px", int'(bus.top_left_x), 280);
    chk("frz_py", int'(bus.top_left_y), 180);
    chk("frz_mode_end", int'(bus.mode), 2);
    bus.freeze = 1'b0;
    tick();
    chk("unfrz_mode", int'(bus.mode), 0);
    do_frame(0, 0, 0, 4'b0000);
    chk("unfrz_vy", int'(dut.vy), -130);
    chk("unfrz_py", int'(bus.top_left_y), 178);
    chk("unfrz_landed", int'(bus.landed), 0);

    // Reset between a press and the frame discards the request.
    do_reset();
    bus.jump_up_n = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.jump_up_n = 1'b1;
    tick();
    chk("rr_px", int'(bus.top_left_x), 280);
    chk("rr_py", int'(bus.top_left_y), 185);
    chk("rr_vy", int'(dut.vy), 20);
    sof_only();
    chk("rr_vy_frame", int'(dut.vy), 30);

    // Long run: walls, floor bounces, hits and jumps against the model.
    do_reset();
    model_reset();
    for (int f = 0; f < 260; f++) begin
      bit up;
      bit l;
      bit r;
      logic [3:0] h;
      up = (f % 37 == 5);
      r  = (f < 200);
      l  = (f == 60);
      h  = (f == 90) ? 4'b0010 : (f == 120) ? 4'b0100 : (f == 150) ? 4'b0001 : 4'b0000;
      do_frame(up, l, r, h);
      model_frame(up, l, r, h);
      model_check(f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
